hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding controller for the in-order RV64 pipeline; sits beside the ID stage.
- Tracks destination registers in flight across STAGES post-issue stages (default EXE, MEM, WB) and raises load-use/RAW stalls.
- Selects a forwarding source per operand and bubbles/flushes younger slots on a branch redirect.
- Supersedes the current stall-free, forward-free pipeline; generalised in stage depth, load latency and redirect point.

Parameters:
- STAGES, 3: post-issue stages tracked; stage 1 = EXE, stage STAGES = WB.
- AW, 5: register address width.
- LOAD_RDY, 2: first stage index at which load data is forwardable (2 = MEM output).
- REDIR_STAGE, 2: stage index whose redirect flushes younger work.
- SW, $clog2(STAGES+1): forward-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  AW  source registers.
- id_rs1_used, id_rs2_used  in  1  operand actually read.
- id_rd  in  AW  destination register.
- id_reg_wen  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- redirect  in  1  taken branch/jump resolved in stage REDIR_STAGE.
- stall  out  1  hold PC and ID register; insert bubble into EXE.
- flush_id  out  1  kill the instruction in ID this cycle.
- fwd1_sel, fwd2_sel  out  SW  0 = register file, k = result of stage k.
- stall_cnt  out  32  count of stall cycles.

Behaviour:
- State: STAGES slots {v, rd, wen, ld}, stall_cnt. On rst==0 at posedge: all v=0, stall_cnt=0. Outputs are combinational from state and inputs, so after reset stall=0, flush_id=0, fwd*_sel=0.
- Match(k, rs): v[k] & wen[k] & rd[k]==rs & rs!=0 & used. x0 never matches.
- Forward: the lowest matching k (youngest) wins. If slot k is a load with k<LOAD_RDY, the operand is not ready. Otherwise fwd_sel=k.
- WB stage (k=STAGES) is forwardable: the regfile write lands at the same edge as the ID read.
- stall = id_valid & ~redirect & (any operand not ready).
- stall_cnt increments each cycle stall=1 and wraps at 2^32-1 -> 0.
- Advance every posedge (no global freeze): slot k+1 <= slot k; slot STAGES retires.
- Slot 1 <= {id_valid & ~stall & ~redirect, id_rd, id_reg_wen, id_is_load}. Stall and redirect give v=0 (bubble).
- Redirect: flush_id=1 in the same cycle. At the edge, slots 2..REDIR_STAGE are written v=0, since their sources were younger than the resolver. The resolver itself advances to REDIR_STAGE+1 normally.
- Redirect overrides stall: stall forced 0, so a flushed instruction is never held.
- Load-use with defaults: a load in EXE plus a dependent in ID gives exactly 1 stall cycle, then fwd_sel=2.
- rst==0 mid-stream drops all in-flight entries regardless of redirect/stall.
- Implementation budget: roughly 150-250 lines.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding as above.
- Undefined: fwd1_sel/fwd2_sel tied to 0. Any match in slots 1..STAGES stalls. WB is treated as not-ready because the read happens before the write.
- Undefined, effect: a dependent instruction waits until its producer has retired.

Test Plan:
- Reset: hold rst=0 for 2 cycles with id_valid=1 -> stall=0, fwd*_sel=0, stall_cnt=0; slots stay empty after release.
- ALU chain: addi x5 issued, then next cycle add x6,x5,x5 -> fwd1_sel=fwd2_sel=1, stall=0. One bubble between them -> fwd_sel=2.
- Load-use: ld x7 then add x8,x7,x0 -> stall=1 for exactly 1 cycle, stall_cnt=1, then fwd1_sel=2. With HAZARD_FWD_EN off -> stall 3 cycles, fwd1_sel=0.
- x0 / unused operand: producer writes x0, or consumer has rs2_used=0 -> no stall, sel=0.
- Redirect: branch reaches stage 2 with redirect=1 while a dependent is stalled in ID -> stall=0, flush_id=1. Next cycle slots 1..2 have v=0, and the branch sits in slot 3.
- Counter wrap: preload-equivalent via 2^32 forced stalls (or a force) -> stall_cnt 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller beside ID: tracks in-flight destinations, stalls, forwards, flushes.
// Forwarding is built only when HAZARD_FWD_EN is defined; otherwise dependents wait for retirement.
module hazard_scoreboard #(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned AW          = 5,
  parameter int unsigned LOAD_RDY    = 2,
  parameter int unsigned REDIR_STAGE = 2,
  parameter int unsigned SW          = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [AW-1:0] id_rd,
  input  logic          id_reg_wen,
  input  logic          id_is_load,
  input  logic          redirect,
  output logic          stall,
  output logic          flush_id,
  output logic [SW-1:0] fwd1_sel,
  output logic [SW-1:0] fwd2_sel,
  output logic [31:0]   stall_cnt
);

  // First stage index at which a producer's result can be consumed.
`ifdef HAZARD_FWD_EN
  localparam int unsigned AluReady  = 1;
  localparam int unsigned LoadReady = LOAD_RDY;
`else
  // Without forwarding nothing is usable until it has left the last stage.
  localparam int unsigned AluReady  = STAGES + 1;
  localparam int unsigned LoadReady = (LOAD_RDY > STAGES) ? LOAD_RDY : STAGES + 1;
`endif

  // Stages 2..REDIR_STAGE hold work younger than the redirecting instruction.
  localparam logic [STAGES:1] KillMask = STAGES'((2 ** REDIR_STAGE) - 2);

  logic [STAGES:1]         v_q, wen_q, ld_q;
  logic [STAGES:1][AW-1:0] rd_q;
  logic [31:0]             stall_cnt_q;
  logic                    nrdy1, nrdy2;
  logic                    slot1_v;
  logic [STAGES:1]         kill;

  // Returns {not_ready, select}; the youngest matching stage wins.
  function automatic logic [SW:0] resolve(input logic [AW-1:0] rs, input logic used);
    logic          nrdy;
    logic [SW-1:0] sel;
    nrdy = 1'b0;
    sel  = '0;
    for (logic [SW-1:0] k = SW'(STAGES); k != '0; k--) begin
      if (v_q[k] && wen_q[k] && (rd_q[k] == rs) && (rs != '0) && used) begin
        nrdy = 32'(k) < (ld_q[k] ? LoadReady : AluReady);
        sel  = nrdy ? '0 : k;
      end
    end
    return {nrdy, sel};
  endfunction

  always_comb begin
    {nrdy1, fwd1_sel} = resolve(id_rs1, id_rs1_used);
    {nrdy2, fwd2_sel} = resolve(id_rs2, id_rs2_used);
    stall             = id_valid & ~redirect & (nrdy1 | nrdy2);
    flush_id          = redirect;
    slot1_v           = id_valid & ~stall & ~redirect;
    kill              = redirect ? KillMask : '0;
    stall_cnt         = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q         <= '0;
      wen_q       <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q   <= {v_q[STAGES-1:1], slot1_v} & ~kill;
      wen_q <= {wen_q[STAGES-1:1], id_reg_wen};
      ld_q  <= {ld_q[STAGES-1:1], id_is_load};
      rd_q  <= {rd_q[STAGES-1:1], id_rd};
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FWD_EN when it is defined.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_wen, id_is_load, redirect;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, flush_id;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [31:0] stall_cnt;

  int errors  = 0;
  int checks  = 0;
  int exp_cnt = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd      (id_rd),
    .id_reg_wen (id_reg_wen),
    .id_is_load (id_is_load),
    .redirect   (redirect),
    .stall      (stall),
    .flush_id   (flush_id),
    .fwd1_sel   (fwd1_sel),
    .fwd2_sel   (fwd2_sel),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one ID-stage instruction at the falling edge, then settle before checking.
  task automatic drive(input int v, input int r1, input int u1, input int r2, input int u2,
                       input int rd, input int w, input int ld, input int rdr);
    @(negedge clk);
    id_valid    = 1'(v);
    id_rs1      = 5'(r1);
    id_rs1_used = 1'(u1);
    id_rs2      = 5'(r2);
    id_rs2_used = 1'(u2);
    id_rd       = 5'(rd);
    id_reg_wen  = 1'(w);
    id_is_load  = 1'(ld);
    redirect    = 1'(rdr);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = '0; id_reg_wen = 1'b0; id_is_load = 1'b0; redirect = 1'b0;

    // Reset held two cycles with a live producer in ID.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd1", 32'(fwd1_sel), 0);
    chk("rst_fwd2", 32'(fwd2_sel), 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_flush", 32'(flush_id), 0);
    rst = 1'b1;
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
    chk("rel_stall", 32'(stall), 0);
    chk("rel_fwd1", 32'(fwd1_sel), 0);
    idle(3);

    // Back-to-back ALU dependency.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    chk("alu_prod_stall", 32'(stall), 0);
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    chk("alu1_stall", 32'(stall), 0);
    chk("alu1_fwd1", 32'(fwd1_sel), 1);
    chk("alu1_fwd2", 32'(fwd2_sel), 1);
`else
    chk("alu1_stall_a", 32'(stall), 1); exp_cnt++;
    chk("alu1_fwd1", 32'(fwd1_sel), 0);
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
    chk("alu1_stall_b", 32'(stall), 1); exp_cnt++;
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
    chk("alu1_stall_c", 32'(stall), 1); exp_cnt++;
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
    chk("alu1_go", 32'(stall), 0);
    chk("alu1_go_fwd2", 32'(fwd2_sel), 0);
`endif
    idle(3);

    // One bubble between producer and consumer.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    idle(1);
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    chk("alu2_stall", 32'(stall), 0);
    chk("alu2_fwd1", 32'(fwd1_sel), 2);
    chk("alu2_fwd2", 32'(fwd2_sel), 2);
`else
    chk("alu2_stall_a", 32'(stall), 1); exp_cnt++;
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
    chk("alu2_stall_b", 32'(stall), 1); exp_cnt++;
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
    chk("alu2_go", 32'(stall), 0);
`endif
    idle(3);

    // Producer in WB while consumer reads.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    idle(2);
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    chk("wb_stall", 32'(stall), 0);
    chk("wb_fwd1", 32'(fwd1_sel), 3);
`else
    chk("wb_stall", 32'(stall), 1); exp_cnt++;
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
    chk("wb_go", 32'(stall), 0);
`endif
    idle(3);
    chk("cnt_after_alu", stall_cnt, 32'(exp_cnt));

    // Load-use.
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    chk("ld_prod_stall", 32'(stall), 0);
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    chk("ld_stall_a", 32'(stall), 1); exp_cnt++;
`ifdef HAZARD_FWD_EN
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    chk("ld_go", 32'(stall), 0);
    chk("ld_fwd1", 32'(fwd1_sel), 2);
    chk("ld_fwd2_x0", 32'(fwd2_sel), 0);
`else
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    chk("ld_stall_b", 32'(stall), 1); exp_cnt++;
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    chk("ld_stall_c", 32'(stall), 1); exp_cnt++;
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    chk("ld_go", 32'(stall), 0);
    chk("ld_fwd1", 32'(fwd1_sel), 0);
`endif
    chk("ld_cnt", stall_cnt, 32'(exp_cnt));
    idle(3);

    // x0 destination and unused operand never match.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("x0_stall", 32'(stall), 0);
    chk("x0_fwd1", 32'(fwd1_sel), 0);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    drive(1, 3, 1, 9, 0, 0, 0, 0, 0);
    chk("unused_stall", 32'(stall), 0);
    chk("unused_fwd2", 32'(fwd2_sel), 0);
    idle(3);

    // Reset mid-stream drops an in-flight producer and clears the counter.
    drive(1, 0, 0, 0, 0, 13, 1, 0, 0);
    idle(1);
    rst = 1'b0;
    drive(1, 13, 1, 13, 1, 0, 0, 0, 0);
    chk("mrst_stall", 32'(stall), 0);
    chk("mrst_fwd1", 32'(fwd1_sel), 0);
    chk("mrst_cnt", stall_cnt, 0);
    rst = 1'b1;
    exp_cnt = 0;
    idle(3);

    // Redirect from stage 2 while a load-dependent sits in ID.
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("br_noflush", 32'(flush_id), 0);
    drive(1, 0, 0, 0, 0, 10, 1, 1, 0);
    chk("br_ld_stall", 32'(stall), 0);
    drive(1, 10, 1, 0, 0, 10, 1, 0, 1);
    chk("redir_stall", 32'(stall), 0);
    chk("redir_flush", 32'(flush_id), 1);
    drive(1, 10, 1, 1, 1, 0, 0, 0, 0);
    chk("post_redir_flush", 32'(flush_id), 0);
`ifdef HAZARD_FWD_EN
    chk("post_redir_stall", 32'(stall), 0);
    chk("post_redir_fwd1", 32'(fwd1_sel), 0);
    chk("post_redir_fwd2", 32'(fwd2_sel), 3);
`else
    chk("post_redir_stall", 32'(stall), 1); exp_cnt++;
    drive(1, 10, 1, 1, 1, 0, 0, 0, 0);
    chk("post_redir_go", 32'(stall), 0);
`endif
    chk("redir_cnt", stall_cnt, 32'(exp_cnt));
    idle(3);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0);
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
    chk("wrap_stall", 32'(stall), 1);
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
    chk("wrap_cnt", stall_cnt, 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
